// File: rtl/credit_stream_tx_pkg.sv
// credit_stream_tx_pkg: shared counter opcodes and width helper for the credit link.
package credit_stream_tx_pkg;
  typedef enum logic [1:0] {CntHold, CntLoad, CntDec, CntInc} cnt_op_e;
  function automatic int unsigned cnt_width(int unsigned n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/credit_stream_tx_credit_counter.sv
// credit_counter: up/down credit counter with load, saturating at NumCredits.
module credit_counter
  import credit_stream_tx_pkg::*;
#(
  parameter int unsigned NumCredits = 32'd8,
  localparam int unsigned CntW = cnt_width(NumCredits)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  cnt_op_e         op_i,
  output logic [CntW-1:0] cnt_o,
  output logic            zero_o,
  output logic            full_o
);
  localparam logic [CntW-1:0] Max = CntW'(NumCredits);
  logic [CntW-1:0] cnt_q, cnt_d;
  assign zero_o = cnt_q == '0;
  assign full_o = cnt_q == Max;
  assign cnt_o  = cnt_q;
  // an increment at full is a receiver protocol error; hold instead of wrapping
  always_comb begin
    cnt_d = op_i == CntLoad ? Max :
            op_i == CntDec  ? cnt_q - CntW'(1) :
            (op_i == CntInc && !full_o) ? cnt_q + CntW'(1) : cnt_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= Max;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/credit_stream_tx.sv
// credit_stream_tx: credit-gated transmit end of a valid-only stream link.
module credit_stream_tx
  import credit_stream_tx_pkg::*;
#(
  parameter int unsigned NumCredits = 32'd8,
  parameter bit CreditBypass = 1'b1,
  parameter type type_t = logic,
  localparam int unsigned CntW = cnt_width(NumCredits)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  type_t           data_i,
  input  logic            valid_i,
  output logic            ready_o,
  output type_t           data_o,
  output logic            valid_o,
  input  logic            credit_i,
  output logic [CntW-1:0] credits_o,
  output logic            idle_o
);
  cnt_op_e cnt_op;
  logic zero, full, send, valid_q;
  type_t data_q;
  credit_counter #(.NumCredits(NumCredits)) u_cnt (
    .clk_i(clk_i), .rst_ni(rst_ni), .op_i(cnt_op),
    .cnt_o(credits_o), .zero_o(zero), .full_o(full)
  );
  assign ready_o = !flush_i && (!zero || (CreditBypass && credit_i));
  assign send    = valid_i && ready_o;
  always_comb begin
    cnt_op = flush_i ? CntLoad :
             (send && credit_i) ? CntHold :
             send ? CntDec :
             credit_i ? CntInc : CntHold;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= send;
      data_q  <= send ? data_i : data_q;
    end
  end
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign idle_o  = full && !valid_q;
  a_no_credit_at_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(credit_i && full && !flush_i));
  a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    credits_o <= CntW'(NumCredits));
  a_stream_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (valid_i && !ready_o) ##1 valid_i |-> $stable(data_i));
endmodule

// File: tb/tb_credit_stream_tx.sv
// tb_credit_stream_tx: vector table, bypass corner cases, randomized receiver model, async reset.
module tb_credit_stream_tx;
  localparam int N = 4;
  localparam int CW = $clog2(N + 1);
  typedef logic [7:0] byte_t;
  logic clk = 0, rst_n = 0, flush = 0, valid = 0, credit = 0, en0 = 1;
  byte_t data = '0;
  logic ready, vo, idle, ready0, vo0, idle0;
  byte_t dout, dout0;
  logic [CW-1:0] cr, cr0;
  int total = 0, bad = 0;
  always #5 clk = ~clk;

  credit_stream_tx #(.NumCredits(N), .CreditBypass(1'b1), .type_t(byte_t)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .data_i(data), .valid_i(valid),
    .ready_o(ready), .data_o(dout), .valid_o(vo), .credit_i(credit),
    .credits_o(cr), .idle_o(idle));
  credit_stream_tx #(.NumCredits(N), .CreditBypass(1'b0), .type_t(byte_t)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .data_i(data), .valid_i(valid && en0),
    .ready_o(ready0), .data_o(dout0), .valid_o(vo0), .credit_i(credit && en0),
    .credits_o(cr0), .idle_o(idle0));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic fl; logic v; byte_t d; logic c;
    logic rdy; logic vo; byte_t dq; int cr;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(logic fl, logic v, byte_t d, logic c, logic rdy, logic o, byte_t dq, int crv);
    vec_t r;
    r.fl = fl; r.v = v; r.d = d; r.c = c; r.rdy = rdy; r.vo = o; r.dq = dq; r.cr = crv;
    return r;
  endfunction

  byte_t sent[$], rx[$];
  int mcr;
  logic mrdy, msend;

  initial begin
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 1, byte_t'(8'h10 + i), 0, 1, 1, byte_t'(8'h10 + i), 3 - i));
    tbl.push_back(mk(0, 1, 8'hA5, 0, 0, 0, 8'h13, 0));
    tbl.push_back(mk(0, 1, 8'hA5, 0, 0, 0, 8'h13, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 8'h13, N));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 1, byte_t'(8'h20 + i), 0, 1, 1, byte_t'(8'h20 + i), 3 - i));
    tbl.push_back(mk(1, 1, 8'h30, 0, 0, 0, 8'h22, N));
    tbl.push_back(mk(0, 1, 8'h30, 0, 1, 1, 8'h30, 3));
    tbl.push_back(mk(0, 1, 8'h31, 0, 1, 1, 8'h31, 2));
    for (int i = 0; i < 10; i++) tbl.push_back(mk(0, 1, byte_t'(8'h40 + i), 1, 1, 1, byte_t'(8'h40 + i), 2));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 8'h49, 3));
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 8'h49, 4));

    #12;
    chk("rst_valid_o", vo, 0);
    chk("rst_data_o", dout, 0);
    chk("rst_credits", cr, N);
    chk("rst_idle", idle, 1);
    chk("rst_ready", ready, 1);
    #5 rst_n = 1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      flush = tbl[i].fl; valid = tbl[i].v; data = tbl[i].d; credit = tbl[i].c;
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i), ready, tbl[i].rdy);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid_o", i), vo, tbl[i].vo);
      chk($sformatf("vec%0d_data_o", i), dout, tbl[i].dq);
      chk($sformatf("vec%0d_credits", i), cr, tbl[i].cr);
    end

    flush = 0; credit = 0; valid = 1;
    for (int i = 0; i < N; i++) begin
      data = byte_t'(8'h50 + i);
      @(posedge clk); #1;
    end
    chk("byp_pre_credits", cr, 0);
    chk("byp_pre_credits0", cr0, 0);
    data = 8'h60; credit = 1;
    @(negedge clk);
    chk("byp_ready", ready, 1);
    chk("nobyp_ready", ready0, 0);
    @(posedge clk); #1;
    chk("byp_valid_o", vo, 1);
    chk("byp_data_o", dout, 8'h60);
    chk("byp_credits", cr, 0);
    chk("nobyp_valid_o", vo0, 0);
    chk("nobyp_credits", cr0, 1);
    credit = 0;
    @(negedge clk);
    chk("byp_ready_after", ready, 0);
    chk("nobyp_ready_after", ready0, 1);
    @(posedge clk); #1;
    chk("nobyp_valid_o2", vo0, 1);
    chk("nobyp_data_o2", dout0, 8'h60);
    chk("nobyp_credits2", cr0, 0);
    chk("byp_valid_o2", vo, 0);
    valid = 0; flush = 1;
    @(posedge clk); #1;
    flush = 0;
    chk("flush_credits", cr, N);
    chk("flush_idle", idle, 1);

    en0 = 0; mcr = N; mrdy = 1;
    for (int i = 0; i < 300; i++) begin
      if (!(valid && !mrdy)) begin
        valid = 1'($urandom_range(0, 1));
        data = byte_t'($urandom);
      end
      credit = (rx.size() > 0) && ($urandom_range(0, 2) != 0);
      mrdy = (mcr > 0) || credit;
      @(negedge clk);
      chk("rand_ready", ready, mrdy);
      msend = valid && mrdy;
      if (msend) sent.push_back(data);
      if (credit) void'(rx.pop_front());
      mcr = mcr + (credit ? 1 : 0) - (msend ? 1 : 0);
      @(posedge clk); #1;
      chk("rand_valid_o", vo, msend);
      if (msend) begin
        chk("rand_data_o", dout, sent.pop_front());
        rx.push_back(dout);
        chk("rand_rx_no_overflow", rx.size() <= N, 1);
      end
      chk("rand_credits", cr, mcr);
    end

    valid = 0; credit = 0; flush = 1;
    @(posedge clk); #1;
    flush = 0; rx.delete();
    chk("drain_credits", cr, N);

    valid = 1; data = 8'h70;
    @(posedge clk); #1;
    data = 8'h71;
    @(posedge clk); #2;
    chk("midburst_valid_o", vo, 1);
    rst_n = 0; valid = 0;
    #1;
    chk("async_rst_valid_o", vo, 0);
    chk("async_rst_credits", cr, N);
    #11 rst_n = 1;
    @(posedge clk); #1;
    chk("post_rst_idle", idle, 1);
    chk("post_rst_ready", ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
